boot_loader: RTL and testbench
==============================

# boot_loader

Hardware bootloader that drives the instruction ROM load port and holds the CPU in reset until a program is loaded. It accepts a framed byte stream on a valid/ready handshake, packs the bytes into 16-bit instruction words, and writes them to consecutive ROM addresses starting at 0. It then checks an XOR checksum and releases the CPU reset after a fixed hold time. It sits between the host link and the ROM/CPU, in place of the simulation-only bootload stimulus.

## Interface
Parameters:
- `ADDR_W`, 8: ROM address width.
- `RESET_HOLD`, 3: cycles `cpu_reset` stays high after a good checksum.

Ports:
- `clock`, in, 1: system clock; all logic on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `in_data`, in, 8: stream byte.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: byte accepted on a cycle where `in_valid & in_ready`.
- `start`, in, 1: single-cycle request to reload. Honoured only in RUN or ERR.
- `boot_active`, out, 1: loader owns the ROM port. Drives the address/data mux select.
- `boot_we`, out, 1: one-cycle ROM write strobe. ROM `we` = `boot_we | cpu write`.
- `boot_addr`, out, ADDR_W: ROM write address.
- `boot_data`, out, 16: ROM write data.
- `cpu_reset`, out, 1: active-high reset to the CPU core.
- `done`, out, 1: load succeeded and the CPU is running.
- `error`, out, 1: checksum mismatch. CPU is held in reset.

## Operation
- Frame format, in order:
  - LEN byte: N words, 0–255.
  - 2N data bytes, high byte first.
  - CSUM byte: XOR of LEN and all data bytes.
- States:
  - LEN: latch N, seed csum = byte. If N=0, go to CSUM; else go to HI.
  - HI: store byte as hi, csum ^= byte, go to LO.
  - LO: csum ^= byte, schedule write of {hi, byte}, decrement the word counter. Go to CSUM when it reaches 0, else go to HI.
  - CSUM: if byte == csum, go to HOLD; else go to ERR.
  - HOLD: count RESET_HOLD cycles, then go to RUN.
  - RUN: hold until `start`.
  - ERR: hold until `start`.
- `start` in RUN or ERR moves to LEN and re-initialises the load:
  - `cpu_reset`=1, `boot_active`=1, `done`=0, `error`=0.
  - `boot_addr` restarts at 0, csum=0.
- `start` in any other state is ignored.
- `in_ready` = 1 in LEN, HI, LO and CSUM; 0 in HOLD, RUN and ERR.
- `boot_active` = 1 in every state except RUN.
- `boot_addr` increments after each write. The maximum written address is N−1 ≤ 254, so no wrap.
- When `in_valid` is low, the FSM stalls with no state change.

## Timing
- Reset values (while `reset`=0):
  - State = LEN.
  - `in_ready`=1, `boot_active`=1, `boot_we`=0, `boot_addr`=0, `boot_data`=0.
  - `cpu_reset`=1, `done`=0, `error`=0.
  - Internal counters and csum are 0.
- Write latency: the LO handshake is at edge k. `boot_we`=1 during cycle k+1 (after edge k), with `boot_addr` and `boot_data` valid in that same cycle. `boot_addr` advances at edge k+1.
- Back-to-back bytes at one per cycle are accepted with no stall. Writes are spaced at least 2 cycles apart.
- CSUM match at edge c:
  - HOLD runs for RESET_HOLD cycles.
  - `cpu_reset` falls and `done` rises together at edge c+RESET_HOLD.
  - `boot_active` falls on that same edge.
- CSUM mismatch at edge c: `error`=1 from edge c. `cpu_reset` stays 1 and `done` stays 0.
- Asynchronous reset asserted mid-frame: outputs return to their reset values immediately, partial data is discarded, and the ROM contents are not touched afterwards.
- `start` and `in_valid` both high in RUN: `start` wins. The byte is not accepted because `in_ready`=0.

## Structure
- Shared package `boot_pkg` holds:
  - The state enum (LEN, HI, LO, CSUM, HOLD, RUN, ERR).
  - The default RESET_HOLD value.
  - The frame-format constants.
- Single module. No sub-module is needed.
- The CPU-side address/data/write-enable mux stays in the top level, selected by `boot_active`.

## Test plan
- Load of 2 words: stream 02,11,21,11,21,00 (csum 02^11^21^11^21 = 02; send CSUM 02).
  - Correct stream: writes 0x1121 to address 0 and 0x1121 to address 1.
  - `cpu_reset` falls 3 cycles after CSUM; `done`=1.
  - Checksum byte: the stream as listed (final byte 00) fails. The bench must send CSUM=02 as the last byte, i.e. 02,11,21,11,21,02.
- Bad checksum: 01,AB,CD, then 00 (expected 01^AB^CD = 67).
  - `error`=1, `cpu_reset` stays 1, one write of 0xABCD at address 0.
- N=0: stream 00,00.
  - No `boot_we` pulse; `done` after 3 hold cycles.
- Stalled source: the 2-word frame with `in_valid` toggling every other cycle.
  - Same writes and result as the unstalled load; `boot_we` never lasts more than 1 cycle.
- Reload and async reset:
  - After `done`, pulse `start`: `cpu_reset`=1 and `boot_addr`=0 on the next cycle, and a new frame loads.
  - Drop `reset` after the 3rd byte: all outputs return to reset values, and a subsequent full frame loads correctly.

Source files
------------

// File: rtl/boot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : boot_pkg
//  Description : Shared types and constants for the ROM bootloader. Holds
//                the loader state encoding, the default CPU reset hold
//                time and the framing widths of the host byte stream.
//  Revision    : 1.0 - initial release
// ============================================================================
package boot_pkg;

  // Loader states, in frame order followed by the terminal states.
  typedef enum logic [2:0] {
    ST_LEN  = 3'd0,
    ST_HI   = 3'd1,
    ST_LO   = 3'd2,
    ST_CSUM = 3'd3,
    ST_HOLD = 3'd4,
    ST_RUN  = 3'd5,
    ST_ERR  = 3'd6
  } boot_state_e;

  // Cycles the CPU stays in reset after a good checksum.
  localparam int unsigned DEFAULT_RESET_HOLD = 3;

  // Frame format: byte-wide stream, 16-bit instruction words sent high
  // byte first, so each word is two stream bytes.
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 2 * BYTE_W;

endpackage : boot_pkg
`default_nettype wire

// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : boot_loader
//  Description : Receives a framed byte stream (LEN, 2*LEN data bytes,
//                XOR checksum) over valid/ready, packs byte pairs into
//                16-bit words and writes them to ROM addresses 0..LEN-1.
//                On a good checksum the CPU is released from reset after
//                RESET_HOLD cycles; on a bad one the loader parks in ERR.
//  Ports       : clock/reset    - clock, async active-low reset
//                in_data/in_valid/in_ready - byte stream handshake
//                start          - reload request (RUN or ERR only)
//                boot_active    - loader owns the ROM port (mux select)
//                boot_we/boot_addr/boot_data - ROM write port
//                cpu_reset      - active-high CPU reset
//                done/error     - load succeeded / checksum mismatch
//  Revision    : 1.0 - initial release
// ============================================================================
module boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned RESET_HOLD = DEFAULT_RESET_HOLD
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              start,
  output logic              boot_active,
  output logic              boot_we,
  output logic [ADDR_W-1:0] boot_addr,
  output logic [WORD_W-1:0] boot_data,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam int unsigned HOLD_W = (RESET_HOLD > 2) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  boot_state_e       state_q, state_d;
  logic [BYTE_W-1:0] cnt_q, cnt_d;     // words still to receive
  logic [BYTE_W-1:0] hi_q, hi_d;       // high byte of the word in flight
  logic [BYTE_W-1:0] csum_q, csum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              w_fire;

  // Status outputs decode straight from the state register so they all
  // change on the same edge as the state transition.
  assign in_ready    = (state_q == ST_LEN) || (state_q == ST_HI) ||
                       (state_q == ST_LO)  || (state_q == ST_CSUM);
  assign boot_active = (state_q != ST_RUN);
  assign cpu_reset   = (state_q != ST_RUN);
  assign done        = (state_q == ST_RUN);
  assign error       = (state_q == ST_ERR);
  assign boot_we     = we_q;
  assign boot_addr   = addr_q;
  assign boot_data   = data_q;

  assign w_fire = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    csum_d  = csum_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    hold_d  = hold_q;

    // The address steps on the edge that ends the write cycle, so the
    // ROM sees a stable address for the whole strobe.
    if (we_q) begin
      addr_d = addr_q + ADDR_W'(1);
    end

    unique case (state_q)
      ST_LEN: begin
        if (w_fire) begin
          cnt_d   = in_data;
          csum_d  = in_data;
          state_d = (in_data == '0) ? ST_CSUM : ST_HI;
        end
      end
      ST_HI: begin
        if (w_fire) begin
          hi_d    = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (w_fire) begin
          csum_d  = csum_q ^ in_data;
          data_d  = {hi_q, in_data};
          we_d    = 1'b1;
          cnt_d   = cnt_q - BYTE_W'(1);
          state_d = (cnt_q == BYTE_W'(1)) ? ST_CSUM : ST_HI;
        end
      end
      ST_CSUM: begin
        if (w_fire) begin
          hold_d  = '0;
          state_d = (in_data == csum_q) ? ST_HOLD : ST_ERR;
        end
      end
      ST_HOLD: begin
        if (hold_q == C_HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_RUN, ST_ERR: begin
        if (start) begin
          state_d = ST_LEN;
          addr_d  = '0;
          csum_d  = '0;
          cnt_d   = '0;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = ST_LEN;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_LEN;
      cnt_q   <= '0;
      hi_q    <= '0;
      csum_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      csum_q  <= csum_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
    end
  end

endmodule : boot_loader
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_boot_loader
//  Description : Directed testbench for boot_loader. Streams hand-built
//                frames, records every ROM write strobe and compares
//                outputs against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_boot_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        start = 1'b0;
  logic        boot_active;
  logic        boot_we;
  logic [7:0]  boot_addr;
  logic [15:0] boot_data;
  logic        cpu_reset;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_errors = 0;

  logic [23:0] wr_q[$];
  logic        we_prev = 1'b0;
  int          we_double = 0;

  boot_loader #(
    .ADDR_W     (8),
    .RESET_HOLD (3)
  ) u_dut (
    .clock       (clock),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .start       (start),
    .boot_active (boot_active),
    .boot_we     (boot_we),
    .boot_addr   (boot_addr),
    .boot_data   (boot_data),
    .cpu_reset   (cpu_reset),
    .done        (done),
    .error       (error)
  );

  always #5 clock = ~clock;

  // Write recorder: samples mid-cycle, logs {addr, data} per strobe and
  // flags any strobe that stays high for two consecutive cycles.
  always @(negedge clock) begin
    if (boot_we) begin
      wr_q.push_back({boot_addr, boot_data});
      if (we_prev) we_double++;
    end
    we_prev = boot_we;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte, wait (bounded) for ready, complete the handshake,
  // then optionally idle for 'gap' cycles while pulsing start.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    if (n == 20) check("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
    end
  endtask

  // Called just after the CSUM handshake edge c of a good frame.
  task automatic check_hold(input string tag);
    check({tag, "_rst_c0"}, 32'(cpu_reset), 32'd1);
    check({tag, "_rdy_c0"}, 32'(in_ready), 32'd0);
    repeat (2) begin @(posedge clock); #1; end
    check({tag, "_rst_c2"}, 32'(cpu_reset), 32'd1);
    check({tag, "_done_c2"}, 32'(done), 32'd0);
    @(posedge clock); #1;
    check({tag, "_rst_c3"}, 32'(cpu_reset), 32'd0);
    check({tag, "_done_c3"}, 32'(done), 32'd1);
    check({tag, "_act_c3"}, 32'(boot_active), 32'd0);
    check({tag, "_err_c3"}, 32'(error), 32'd0);
  endtask

  task automatic pulse_start(input logic with_valid);
    start    = 1'b1;
    in_valid = with_valid;
    in_data  = 8'h05;
    @(posedge clock); #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    // ---------------- reset values ----------------
    #2;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_active", 32'(boot_active), 32'd1);
    check("rst_we", 32'(boot_we), 32'd0);
    check("rst_addr", 32'(boot_addr), 32'd0);
    check("rst_data", 32'(boot_data), 32'd0);
    check("rst_cpu", 32'(cpu_reset), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(error), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;

    // ---------------- 2-word load, back to back ----------------
    wr_q.delete();
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h21, 0);
    check("l1_we_k1", 32'(boot_we), 32'd1);
    check("l1_addr_k1", 32'(boot_addr), 32'd0);
    check("l1_data_k1", 32'(boot_data), 32'h1121);
    send_byte(8'h11, 0);
    check("l1_addr_adv", 32'(boot_addr), 32'd1);
    send_byte(8'h21, 0);
    send_byte(8'h02, 0);
    check_hold("l1");
    check("l1_addr_end", 32'(boot_addr), 32'd2);
    check("l1_nwr", 32'(wr_q.size()), 32'd2);
    if (wr_q.size() == 2) begin
      check("l1_wr0", 32'(wr_q[0]), 32'h001121);
      check("l1_wr1", 32'(wr_q[1]), 32'h011121);
    end

    // ---------------- reload with start + in_valid together ----------------
    pulse_start(1'b1);
    check("rl_cpu", 32'(cpu_reset), 32'd1);
    check("rl_addr", 32'(boot_addr), 32'd0);
    check("rl_done", 32'(done), 32'd0);
    check("rl_active", 32'(boot_active), 32'd1);
    check("rl_ready", 32'(in_ready), 32'd1);

    // ---------------- bad checksum ----------------
    wr_q.delete();
    send_byte(8'h01, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    send_byte(8'h00, 0);
    check("bad_err_c", 32'(error), 32'd1);
    repeat (4) begin @(posedge clock); #1; end
    check("bad_err", 32'(error), 32'd1);
    check("bad_cpu", 32'(cpu_reset), 32'd1);
    check("bad_done", 32'(done), 32'd0);
    check("bad_ready", 32'(in_ready), 32'd0);
    check("bad_nwr", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() == 1) check("bad_wr0", 32'(wr_q[0]), 32'h00ABCD);

    // ---------------- N = 0 from ERR ----------------
    pulse_start(1'b0);
    check("z_err_clr", 32'(error), 32'd0);
    wr_q.delete();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check_hold("z");
    check("z_nwr", 32'(wr_q.size()), 32'd0);

    // ---------------- stalled source, start ignored mid-frame ----------------
    pulse_start(1'b0);
    wr_q.delete();
    we_double = 0;
    send_byte(8'h02, 1);
    send_byte(8'h11, 1);
    send_byte(8'h21, 1);
    send_byte(8'h11, 1);
    send_byte(8'h21, 1);
    send_byte(8'h02, 0);
    check_hold("st");
    check("st_nwr", 32'(wr_q.size()), 32'd2);
    if (wr_q.size() == 2) begin
      check("st_wr0", 32'(wr_q[0]), 32'h001121);
      check("st_wr1", 32'(wr_q[1]), 32'h011121);
    end
    check("st_we_1cyc", 32'(we_double), 32'd0);

    // ---------------- async reset mid-frame ----------------
    pulse_start(1'b0);
    wr_q.delete();
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h21, 0);
    reset = 1'b0;
    #1;
    check("ar_ready", 32'(in_ready), 32'd1);
    check("ar_active", 32'(boot_active), 32'd1);
    check("ar_we", 32'(boot_we), 32'd0);
    check("ar_addr", 32'(boot_addr), 32'd0);
    check("ar_data", 32'(boot_data), 32'd0);
    check("ar_cpu", 32'(cpu_reset), 32'd1);
    check("ar_done", 32'(done), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    check("ar_nwr", 32'(wr_q.size()), 32'd0);
    @(posedge clock); #1;
    // 02^12^34^56^78 = 0A
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h56, 0);
    send_byte(8'h78, 0);
    send_byte(8'h0A, 0);
    check_hold("ar2");
    check("ar2_nwr", 32'(wr_q.size()), 32'd2);
    if (wr_q.size() == 2) begin
      check("ar2_wr0", 32'(wr_q[0]), 32'h001234);
      check("ar2_wr1", 32'(wr_q[1]), 32'h015678);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_boot_loader
`default_nettype wire
